// File: rtl/led_pattern_engine_pkg.sv
// Shared definitions for the LED pattern engine: mode encoding, direction
// constants and the mode-advance helper.
package led_pattern_engine_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Modes cycle SHIFT -> ROTATE -> BOUNCE -> COUNT -> SHIFT.
  function automatic mode_e next_mode(input mode_e m);
    logic [1:0] w_m;
    w_m = m;
    return mode_e'(w_m + 2'd1);
  endfunction

endpackage

// File: rtl/led_pattern_engine_key_conditioner.sv
// Conditions one raw active-low push-button into a single-cycle press event.
// Build option LED_PATTERN_DEBOUNCE_EN: when defined, a debounce counter sits
// behind the synchroniser; when undefined, only the synchroniser and the
// edge detect remain (short latency for simulation) and DEB_CNT is unused.
module key_conditioner
  import led_pattern_engine_pkg::*;
#(
  parameter int DEB_CNT = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;

  // Two-flop synchroniser; idle level is released (1).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef LED_PATTERN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CNT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CNT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             w_accept;

  // Level differs from the accepted one and has stayed put for DEB_CNT cycles.
  assign w_accept = (r_sync2 != r_level) && (r_cnt == '0);

  // Down-counter reloads whenever the synchronised level matches the accepted
  // level, so any bounce back restarts the stability window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= 1'b1;
      r_cnt   <= CNT_LOAD;
    end else if (r_sync2 == r_level) begin
      r_cnt <= CNT_LOAD;
    end else if (w_accept) begin
      r_level <= r_sync2;
      r_cnt   <= CNT_LOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_press = w_accept & ~r_sync2;
`else
  logic r_level;
  logic w_unused_deb;

  assign w_unused_deb = (DEB_CNT >= 2);

  // Previous synchronised level for the falling-edge (press) detect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= 1'b1;
    end else begin
      r_level <= r_sync2;
    end
  end

  assign o_press = r_level & ~r_sync2;
`endif

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: free-running prescaler, step/blink tick detection,
// three conditioned buttons and the four-mode pattern datapath.
// Build option LED_PATTERN_DEBOUNCE_EN enables full key debounce.
//
// mode   | meaning
// SHIFT  | shift toward dir, source bit holds; blink tick inverts source bit
// ROTATE | circular rotate by one toward dir
// BOUNCE | single lit bit walks and reverses at the ends (owns dir)
// COUNT  | binary up/down counter modulo 2^LED_W
module led_pattern_engine
  import led_pattern_engine_pkg::*;
#(
  parameter int LED_W     = 8,
  parameter int PRESC_W   = 28,
  parameter int STEP_BIT  = 23,
  parameter int BLINK_BIT = 25,
  parameter int DEB_CNT   = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [2:0]       KEY,
  input  logic [1:0]       SPEED,
  output logic [LED_W-1:0] LEDG,
  output logic [1:0]       MODE,
  output logic             PAUSED
);

  logic [PRESC_W-1:0] r_presc;
  logic               r_step_tap_d;
  logic               r_blink_tap_d;
  logic               w_step_tap;
  logic               w_blink_tap;
  logic               w_step_tick;
  logic               w_blink_tick;
  logic [2:0]         w_press;

  mode_e              r_mode;
  mode_e              w_mode_nxt;
  logic [LED_W-1:0]   r_led;
  logic [LED_W-1:0]   w_led_nxt;
  logic               r_paused;
  logic               w_paused_nxt;
  logic               r_dir;
  logic               w_dir_nxt;

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    key_conditioner #(.DEB_CNT(DEB_CNT)) u_key (
      .i_clk   (CLOCK_50),
      .i_rst_n (RESET_N),
      .i_key_n (KEY[gi]),
      .o_press (w_press[gi])
    );
  end

  // Step tap moves one bit lower per SPEED increment, doubling the rate.
  always_comb begin
    w_step_tap = r_presc[STEP_BIT];
    case (SPEED)
      2'd0:    w_step_tap = r_presc[STEP_BIT];
      2'd1:    w_step_tap = r_presc[STEP_BIT-1];
      2'd2:    w_step_tap = r_presc[STEP_BIT-2];
      default: w_step_tap = r_presc[STEP_BIT-3];
    endcase
  end

  assign w_blink_tap  = r_presc[BLINK_BIT];
  assign w_step_tick  = w_step_tap & ~r_step_tap_d;
  assign w_blink_tick = w_blink_tap & ~r_blink_tap_d;

  // Free-running prescaler and previous tap values for rising-edge detect.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_presc       <= '0;
      r_step_tap_d  <= 1'b0;
      r_blink_tap_d <= 1'b0;
    end else begin
      r_presc       <= r_presc + 1'b1;
      r_step_tap_d  <= w_step_tap;
      r_blink_tap_d <= w_blink_tap;
    end
  end

  // Next pattern/mode/pause/direction. All reads use current register values,
  // so coincident events see the pre-update pause, direction and LED bits.
  always_comb begin
    w_mode_nxt   = r_mode;
    w_led_nxt    = r_led;
    w_paused_nxt = r_paused ^ w_press[1];
    w_dir_nxt    = r_dir;

    if (w_press[0]) begin
      w_mode_nxt = next_mode(r_mode);
      if (w_mode_nxt == MODE_ROTATE || w_mode_nxt == MODE_BOUNCE) begin
        w_led_nxt = LED_W'(1);
      end else begin
        w_led_nxt = '0;
      end
      if (w_mode_nxt == MODE_BOUNCE) begin
        w_dir_nxt = DIR_UP;
      end else if (w_press[2]) begin
        w_dir_nxt = ~r_dir;
      end
    end else begin
      if (w_press[2] && r_mode != MODE_BOUNCE) begin
        w_dir_nxt = ~r_dir;
      end
      if (w_step_tick && !r_paused) begin
        unique case (r_mode)
          MODE_SHIFT: begin
            if (r_dir == DIR_UP) w_led_nxt = {r_led[LED_W-2:0], r_led[0]};
            else                 w_led_nxt = {r_led[LED_W-1], r_led[LED_W-1:1]};
          end
          MODE_ROTATE: begin
            if (r_dir == DIR_UP) w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
            else                 w_led_nxt = {r_led[0], r_led[LED_W-1:1]};
          end
          MODE_BOUNCE: begin
            if (r_dir == DIR_UP) begin
              if (r_led[LED_W-1]) begin
                w_led_nxt = r_led >> 1;
                w_dir_nxt = DIR_DOWN;
              end else begin
                w_led_nxt = r_led << 1;
              end
            end else begin
              if (r_led[0]) begin
                w_led_nxt = r_led << 1;
                w_dir_nxt = DIR_UP;
              end else begin
                w_led_nxt = r_led >> 1;
              end
            end
          end
          MODE_COUNT: begin
            if (r_dir == DIR_UP) w_led_nxt = r_led + 1'b1;
            else                 w_led_nxt = r_led - 1'b1;
          end
        endcase
      end
      // The shifted value kept the source bit; inverting it here combines
      // step and blink from the same old register values.
      if (w_blink_tick && r_mode == MODE_SHIFT) begin
        if (r_dir == DIR_UP) w_led_nxt[0]       = ~r_led[0];
        else                 w_led_nxt[LED_W-1] = ~r_led[LED_W-1];
      end
    end
  end

  // Pattern state registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mode   <= MODE_SHIFT;
      r_led    <= '0;
      r_paused <= 1'b0;
      r_dir    <= DIR_UP;
    end else begin
      r_mode   <= w_mode_nxt;
      r_led    <= w_led_nxt;
      r_paused <= w_paused_nxt;
      r_dir    <= w_dir_nxt;
    end
  end

  assign LEDG   = r_led;
  assign MODE   = r_mode;
  assign PAUSED = r_paused;

endmodule
